// File: rtl/dmem_initiator_pkg.sv
// -----------------------------------------------------------------------------
// dmem_initiator_pkg
// Shared definitions for the data-memory load/store initiator:
//   - FSM state encoding
//   - RV32I load/store funct3 codes
//   - size field values of the memory sign_mask ({signed, size[2:0]})
// -----------------------------------------------------------------------------
package dmem_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Size field of sign_mask (thermometer style: one bit per byte lane pair)
    localparam logic [2:0] SIZE_NONE = 3'b000;
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;

    // Alignment rule for a given access size and the two low address bits.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = (addr_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_req_decode.sv
// -----------------------------------------------------------------------------
// dmem_req_decode
// Purely combinational decode of one load/store request.
//   we          in  1   1 = store, 0 = load
//   funct3      in  3   RV32I load/store funct3
//   addr_lo     in  2   low byte-address bits
//   sign_mask   out 4   {signed, size[2:0]}; signed only for LB/LH
//   illegal     out 1   funct3 not a legal load/store for this direction
//   misaligned  out 1   half on odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module dmem_req_decode
    import dmem_initiator_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [3:0] sign_mask,
    output logic       illegal,
    output logic       misaligned
);

    logic [2:0] size_s;
    logic       signed_s;

    // funct3 -> access size, signedness and legality
    always_comb begin
        size_s   = SIZE_NONE;
        signed_s = 1'b0;
        illegal  = 1'b0;
        if (we) begin
            // stores never request sign extension
            case (funct3)
                F3_SB:   size_s = SIZE_BYTE;
                F3_SH:   size_s = SIZE_HALF;
                F3_SW:   size_s = SIZE_WORD;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB: begin
                    size_s   = SIZE_BYTE;
                    signed_s = 1'b1;
                end
                F3_LH: begin
                    size_s   = SIZE_HALF;
                    signed_s = 1'b1;
                end
                F3_LW:   size_s = SIZE_WORD;
                F3_LBU:  size_s = SIZE_BYTE;
                F3_LHU:  size_s = SIZE_HALF;
                default: illegal = 1'b1;
            endcase
        end
    end

    // assemble mask and alignment flag
    always_comb begin
        sign_mask  = {signed_s, size_s};
        misaligned = is_misaligned(size_s, addr_lo);
    end

endmodule

// File: rtl/dmem_initiator.sv
// -----------------------------------------------------------------------------
// dmem_initiator
// CPU-side load/store initiator for a stall-handshaked data memory. One request
// is accepted at a time, a single-cycle memread/memwrite strobe is issued, the
// memory's clk_stall rise and fall are tracked, and a one-cycle response pulse
// carries the load data or an error (illegal, misaligned, timeout).
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_funct3             store flag and RV32I funct3
//   req_addr, req_wdata            byte address and right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response; rdata is 0 for stores/errors
//   mem_addr, mem_write_data       latched request towards the memory
//   mem_memwrite, mem_memread      single-cycle strobes
//   mem_sign_mask                  {signed, size[2:0]}
//   mem_read_data, mem_clk_stall   memory return data and busy flag
// -----------------------------------------------------------------------------
module dmem_initiator
    import dmem_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    state_e      state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic        cnt_clr_s, cnt_inc_s, err_s;
    logic        timeout_s;
    logic        we_r;
    logic        req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0] rsp_rdata_r, mem_addr_r, mem_write_data_r;
    logic [3:0]  mem_sign_mask_r;

    logic [3:0]  dec_mask_s;
    logic        dec_illegal_s, dec_misaligned_s;

    dmem_req_decode u_decode (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .sign_mask  (dec_mask_s),
        .illegal    (dec_illegal_s),
        .misaligned (dec_misaligned_s)
    );

    // The counter "reaches" the limit on the edge where it would step to it.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, counter control and error decision
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (dec_illegal_s || dec_misaligned_s) begin
                        // rejected before the memory is ever touched
                        next_state_s = RESP;
                        err_s        = 1'b1;
                    end else begin
                        next_state_s = ISSUE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                // a stall here is left over from an aborted transaction
                if (mem_clk_stall) begin
                    if (timeout_s) begin
                        next_state_s = RESP;
                        err_s        = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    next_state_s = WAIT_ACK;
                    cnt_clr_s    = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (mem_clk_stall) begin
                    next_state_s = WAIT_DONE;
                    cnt_clr_s    = 1'b1;
                end else if (timeout_s) begin
                    next_state_s = RESP;
                    err_s        = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!mem_clk_stall) begin
                    next_state_s = RESP;
                end else if (timeout_s) begin
                    next_state_s = RESP;
                    err_s        = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            RESP: begin
                next_state_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // Strobes: the memory samples them on the edge closing the ISSUE cycle, so
    // they are decoded from the state register and gated by the live stall.
    // ISSUE is always left after a strobe, so two consecutive strobes cannot occur.
    always_comb begin
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        if ((state_r == ISSUE) && !mem_clk_stall) begin
            mem_memwrite = we_r;
            mem_memread  = ~we_r;
        end else begin
            mem_memwrite = 1'b0;
            mem_memread  = 1'b0;
        end
    end

    // Wait-state timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request latch towards the memory; held until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_r       <= 32'h0000_0000;
            mem_write_data_r <= 32'h0000_0000;
            mem_sign_mask_r  <= 4'b0000;
            we_r             <= 1'b0;
        end else if ((state_r == IDLE) && req_valid) begin
            mem_addr_r       <= req_addr;
            mem_write_data_r <= req_wdata;
            mem_sign_mask_r  <= dec_mask_s;
            we_r             <= req_we;
        end
    end

    // Response and ready registers; rdata only changes on entry to RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            req_ready_r <= (next_state_s == IDLE);
            rsp_valid_r <= (next_state_s == RESP);
            rsp_err_r   <= (next_state_s == RESP) && err_s;
            if (next_state_s == RESP) begin
                rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : mem_read_data;
            end
        end
    end

    assign req_ready      = req_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_err        = rsp_err_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_write_data_r;
    assign mem_sign_mask  = mem_sign_mask_r;

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator: the driver pushes expected responses and
// expected strobes; independent monitors pop and compare them.
module tb_dmem_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    dmem_initiator dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;   // posedges from accept edge to response; -1 = don't care
        int          acc;
    } exp_rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } exp_stb_t;

    exp_rsp_t exp_q[$];
    exp_stb_t stb_q[$];

    // memory model knobs
    int          mem_stall_len = 2;
    logic        mem_never = 1'b0;
    logic [31:0] mem_word = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: sample strobe, stall for mem_stall_len cycles, return data.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [1:0]  m_lo = 2'b00;
    logic [3:0]  m_mask = 4'b0000;
    logic        m_rd = 1'b0;

    function automatic logic [31:0] mem_extract(input logic [31:0] w, input logic [1:0] lo,
                                                input logic [3:0] m);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (m[2:0])
            3'b001:  return m[3] ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            3'b011:  return m[3] ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt == 1) begin
                mem_clk_stall <= 1'b0;
                m_busy        <= 1'b0;
                mem_read_data <= m_rd ? mem_extract(mem_word, m_lo, m_mask) : 32'hBAD0_BAD0;
            end
            m_cnt <= m_cnt - 1;
        end else if ((mem_memread || mem_memwrite) && !mem_never) begin
            m_busy        <= 1'b1;
            mem_clk_stall <= 1'b1;
            m_cnt         <= mem_stall_len;
            m_lo          <= mem_addr[1:0];
            m_mask        <= mem_sign_mask;
            m_rd          <= mem_memread;
        end
    end

    // Monitor: responses and strobes, sampled on the falling edge
    initial begin
        exp_rsp_t e;
        exp_stb_t s;
        logic     prev_stb;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                        if (e.lat >= 0) chk("rsp_latency", cyc - e.acc, e.lat);
                    end
                end
                if (mem_memread || mem_memwrite) begin
                    chk("stb_onehot", {31'd0, mem_memread & mem_memwrite}, 32'd0);
                    chk("stb_repeat", {31'd0, prev_stb}, 32'd0);
                    chk("stb_during_stall", {31'd0, mem_clk_stall}, 32'd0);
                    if (stb_q.size() == 0) begin
                        chk("unexpected_strobe", 32'd1, 32'd0);
                    end else begin
                        s = stb_q.pop_front();
                        chk("stb_we", {31'd0, mem_memwrite}, {31'd0, s.we});
                        chk("stb_addr", mem_addr, s.addr);
                        chk("stb_wdata", mem_write_data, s.wdata);
                        chk("stb_mask", {28'd0, mem_sign_mask}, {28'd0, s.mask});
                    end
                end
                prev_stb = mem_memread || mem_memwrite;
            end else begin
                prev_stb = 1'b0;
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic push_rsp, input logic err,
                         input logic [31:0] rdata, input int lat, input logic push_stb,
                         input logic [3:0] mask);
        int n;
        exp_rsp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        if (push_stb) stb_q.push_back('{we, addr, wdata, mask});
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push_rsp) begin
            e.err = err; e.rdata = rdata; e.lat = lat; e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rsp_wait_bound", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_sign_mask}, 32'd0);
        chk("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        reset = 1'b0;

        // LW: response 4 edges after accept
        mem_word = 32'hDEAD_BEEF;
        issue(1'b0, 3'b010, 32'h0000_4004, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4, 1'b1, 4'b0111);
        wait_done();

        // SB: store returns rdata 0
        issue(1'b1, 3'b000, 32'h0000_4003, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 4, 1'b1, 4'b0001);
        wait_done();

        // Rejected requests: response on the accept edge, no strobe
        issue(1'b0, 3'b001, 32'h0000_4001, 32'h0, 1'b1, 1'b1, 32'h0, 0, 1'b0, 4'b0000); // LH odd
        issue(1'b0, 3'b011, 32'h0000_4000, 32'h0, 1'b1, 1'b1, 32'h0, 0, 1'b0, 4'b0000); // f3 011
        issue(1'b0, 3'b110, 32'h0000_4000, 32'h0, 1'b1, 1'b1, 32'h0, 0, 1'b0, 4'b0000); // f3 110
        issue(1'b1, 3'b100, 32'h0000_4000, 32'h1, 1'b1, 1'b1, 32'h0, 0, 1'b0, 4'b0000); // store f3 100
        issue(1'b1, 3'b010, 32'h0000_4002, 32'h1, 1'b1, 1'b1, 32'h0, 0, 1'b0, 4'b0000); // SW misaligned
        wait_done();

        // Half accesses on lane 2
        mem_word = 32'hBEEF_1234;
        issue(1'b0, 3'b101, 32'h0000_4006, 32'h0, 1'b1, 1'b0, 32'h0000_BEEF, 4, 1'b1, 4'b0011); // LHU
        issue(1'b0, 3'b001, 32'h0000_4002, 32'h0, 1'b1, 1'b0, 32'hFFFF_BEEF, 4, 1'b1, 4'b1011); // LH
        issue(1'b1, 3'b001, 32'h0000_4002, 32'h0000_1234, 1'b1, 1'b0, 32'h0, 4, 1'b1, 4'b0011); // SH
        wait_done();

        // Timeout: memory never stalls -> 1 ISSUE cycle + 16 WAIT_ACK cycles
        mem_never = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_4010, 32'h0, 1'b1, 1'b1, 32'h0, 17, 1'b1, 4'b0111);
        wait_done();
        @(negedge clk);
        chk("ready_after_timeout", {31'd0, req_ready}, 32'd1);
        mem_never = 1'b0;

        // Reset while in WAIT_DONE with a long memory stall
        mem_stall_len = 8;
        mem_word = 32'h1111_2222;
        issue(1'b0, 3'b010, 32'h0000_4020, 32'h0, 1'b0, 1'b0, 32'h0, -1, 1'b1, 4'b0111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mem_stall_len = 2;
        #1;
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mask", {28'd0, mem_sign_mask}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // ISSUE waits out the old stall (drops 9 edges after the aborted accept),
        // then a normal 4-edge sequence follows: 7 edges from this accept.
        mem_word = 32'h1234_5678;
        issue(1'b0, 3'b010, 32'h0000_4008, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 7, 1'b1, 4'b0111);
        wait_done();

        // Back-to-back LBU then LB on byte 0x80
        mem_word = 32'h0080_0000;
        issue(1'b0, 3'b100, 32'h0000_4002, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 4, 1'b1, 4'b0001);
        issue(1'b0, 3'b000, 32'h0000_4002, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 4, 1'b1, 4'b1001);
        wait_done();
        repeat (3) @(negedge clk);
        chk("rdata_hold", rsp_rdata, 32'hFFFF_FF80);
        chk("mask_hold", {28'd0, mem_sign_mask}, 32'h0000_0009);

        chk("strobe_queue_empty", stb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
